// File: rtl/sync_fifo_pro.sv
// Parametrised single-clock FIFO with registered read data, handshake pulses and occupancy flags.
// Optional high-water mark on max_count is enabled by defining FIFO_HIGH_WATERMARK_EN.
module sync_fifo_pro #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      max_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 || AE_LEVEL < 1 || AE_LEVEL >= AF_LEVEL ||
      AF_LEVEL >= FIFO_DEPTH || CNT_W != $clog2(FIFO_DEPTH + 1)) begin : g_param_err
    $error("sync_fifo_pro: illegal parameter combination");
  end

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [FIFO_WIDTH-1:0] r_data_out;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CNT_W-1:0]      w_count_next;

  // Wrap by explicit compare so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full        = (r_count == DEPTH_C);
  assign empty       = (r_count == '0);
  assign almostfull  = (r_count >= AF_C) && !full;
  assign almostempty = !empty && (r_count <= AE_C);

  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_count_next = r_count;
    if (flush)
      w_count_next = '0;
    else if (w_wr_acc && !w_rd_acc)
      w_count_next = r_count + 1'b1;
    else if (!w_wr_acc && w_rd_acc)
      w_count_next = r_count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= wr_en && full;
      r_underflow <= rd_en && empty;
      if (w_wr_acc)
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_acc) begin
        r_rd_ptr   <= ptr_inc(r_rd_ptr);
        r_data_out <= r_mem[r_rd_ptr];
      end
    end
  end

  // NOTE: storage has no reset; contents are only observable after being written.
  always_ff @(posedge clk) begin
    if (!flush && w_wr_acc)
      r_mem[r_wr_ptr] <= data_in;
  end

`ifdef FIFO_HIGH_WATERMARK_EN
  logic [CNT_W-1:0] r_max_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_max_count <= '0;
    else if (flush)
      r_max_count <= '0;
    else if (w_count_next > r_max_count)
      r_max_count <= w_count_next;
  end

  assign max_count = r_max_count;
`else
  assign max_count = '0;
`endif

  assign data_out  = r_data_out;
  assign wr_ack    = r_wr_ack;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign count     = r_count;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Scoreboard bench for sync_fifo_pro: depth-8 and depth-5 instances, directed vectors,
// expectations queued at stimulus time and compared by an independent negedge monitor.
module tb_sync_fifo_pro;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        fl8, wr8, rd8;
  logic [15:0] din8, dout8;
  logic        ack8, ovf8, udf8, full8, empty8, af8, ae8;
  logic [3:0]  cnt8, max8;

  logic        fl5, wr5, rd5;
  logic [15:0] din5, dout5;
  logic        ack5, ovf5, udf5, full5, empty5, af5, ae5;
  logic [2:0]  cnt5, max5;

  sync_fifo_pro u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(fl8), .wr_en(wr8), .data_in(din8), .rd_en(rd8),
    .data_out(dout8), .wr_ack(ack8), .overflow(ovf8), .underflow(udf8), .full(full8),
    .empty(empty8), .almostfull(af8), .almostempty(ae8), .count(cnt8), .max_count(max8)
  );

  sync_fifo_pro #(.FIFO_DEPTH(5), .AF_LEVEL(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .flush(fl5), .wr_en(wr5), .data_in(din5), .rd_en(rd5),
    .data_out(dout5), .wr_ack(ack5), .overflow(ovf5), .underflow(udf5), .full(full5),
    .empty(empty5), .almostfull(af5), .almostempty(ae5), .count(cnt5), .max_count(max5)
  );

  typedef struct {
    bit          sel;
    string       name;
    logic [15:0] dout;
    logic        ack, ovf, udf, full, empty, af, ae;
    int          cnt;
    int          mx;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mq[$];
  logic [15:0] m_dout;
  int          m_max;
  int          m_depth;
  int          n_vec = 0;
  int          n_err = 0;

`ifdef FIFO_HIGH_WATERMARK_EN
  localparam int HW_PRE_FLUSH = 3;
`else
  localparam int HW_PRE_FLUSH = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fl8 = 0; wr8 = 0; rd8 = 0; din8 = '0;
    fl5 = 0; wr5 = 0; rd5 = 0; din5 = '0;
  endtask

  // Drive one cycle, advance the reference queue model, queue the post-edge expectation.
  task automatic step(input bit sel, input logic wr, input logic [15:0] din,
                      input logic rd, input logic fl, input string name);
    exp_t e;
    bit   fp, ep, wa, ra;
    idle_inputs();
    if (!sel) begin fl8 = fl; wr8 = wr; rd8 = rd; din8 = din; end
    else      begin fl5 = fl; wr5 = wr; rd5 = rd; din5 = din; end
    fp = (mq.size() == m_depth);
    ep = (mq.size() == 0);
    if (fl) begin
      mq.delete();
      e.ack = 0; e.ovf = 0; e.udf = 0;
      m_max = 0;
    end else begin
      wa = wr && !fp;
      ra = rd && !ep;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(din);
      e.ack = wa; e.ovf = wr && fp; e.udf = rd && ep;
`ifdef FIFO_HIGH_WATERMARK_EN
      if (mq.size() > m_max) m_max = mq.size();
`endif
    end
    e.sel   = sel;
    e.name  = name;
    e.dout  = m_dout;
    e.cnt   = mq.size();
    e.mx    = m_max;
    e.full  = (mq.size() == m_depth);
    e.empty = (mq.size() == 0);
    e.af    = (mq.size() >= m_depth - 1) && (mq.size() < m_depth);
    e.ae    = (mq.size() > 0) && (mq.size() <= 1);
    @(posedge clk);
    sb.push_back(e);
    #1;
    idle_inputs();
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_max  = 0;
  endtask

  // Monitor: compares each queued expectation on the falling edge after its clock edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.sel) begin
          check({e.name, ".dout"},  dout8,      e.dout);
          check({e.name, ".ack"},   ack8,       e.ack);
          check({e.name, ".ovf"},   ovf8,       e.ovf);
          check({e.name, ".udf"},   udf8,       e.udf);
          check({e.name, ".full"},  full8,      e.full);
          check({e.name, ".empty"}, empty8,     e.empty);
          check({e.name, ".af"},    af8,        e.af);
          check({e.name, ".ae"},    ae8,        e.ae);
          check({e.name, ".count"}, 32'(cnt8),  e.cnt);
          check({e.name, ".max"},   32'(max8),  e.mx);
        end else begin
          check({e.name, ".dout"},  dout5,      e.dout);
          check({e.name, ".ack"},   ack5,       e.ack);
          check({e.name, ".ovf"},   ovf5,       e.ovf);
          check({e.name, ".udf"},   udf5,       e.udf);
          check({e.name, ".full"},  full5,      e.full);
          check({e.name, ".empty"}, empty5,     e.empty);
          check({e.name, ".af"},    af5,        e.af);
          check({e.name, ".ae"},    ae5,        e.ae);
          check({e.name, ".count"}, 32'(cnt5),  e.cnt);
          check({e.name, ".max"},   32'(max5),  e.mx);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    idle_inputs();
    rd8 = 1'b1;
    m_depth = 8;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.empty", empty8, 1);
    check("rst.count", cnt8, 0);
    check("rst.dout",  dout8, 0);
    check("rst.full",  full8, 0);
    check("rst.af",    af8, 0);
    check("rst.ae",    ae8, 0);
    check("rst.udf",   udf8, 0);
    check("rst.max",   max8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 16'h0, 1, 0, "rst_release_rd");

    for (int i = 1; i <= 8; i++) step(0, 1, 16'(i), 0, 0, "fill");
    step(0, 1, 16'hDEAD, 0, 0, "overflow");
    step(0, 1, 16'hBEEF, 1, 0, "full_wr_rd");
    for (int i = 0; i < 7; i++) step(0, 0, 16'h0, 1, 0, "drain");
    step(0, 0, 16'h0, 1, 0, "underflow");
    step(0, 1, 16'h1234, 1, 0, "empty_wr_rd");
    step(0, 0, 16'h0, 1, 0, "read_1234");
    wait_sb();
    check("hand.dout_1234", dout8, 16'h1234);

    step(0, 0, 16'h0, 0, 1, "flush_idle");
    step(0, 1, 16'h00A1, 0, 0, "pre_flush_wr");
    step(0, 1, 16'h00A2, 0, 0, "pre_flush_wr");
    step(0, 1, 16'h00A3, 0, 0, "pre_flush_wr");
    wait_sb();
    check("hand.max_pre_flush", 32'(max8), HW_PRE_FLUSH);
    step(0, 1, 16'h00A4, 0, 1, "flush_with_wr");
    step(0, 0, 16'h0, 1, 0, "post_flush_rd");
    wait_sb();
    check("hand.max_post_flush", max8, 0);

    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h00B1 + i), 0, 0, "burst");
    wait_sb();
    check("hand.burst_count", cnt8, 4);
    check("hand.burst_ack",   ack8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.count", cnt8, 0);
    check("async_rst.empty", empty8, 1);
    check("async_rst.af",    af8, 0);
    check("async_rst.ae",    ae8, 0);
    check("async_rst.ack",   ack8, 0);
    check("async_rst.ovf",   ovf8, 0);
    check("async_rst.udf",   udf8, 0);
    check("async_rst.dout",  dout8, 0);
    check("async_rst.max",   max8, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 16'h0, 0, 0, "post_rst_idle");
    wait_sb();

    m_depth = 5;
    model_reset();
    for (int g = 0; g < 6; g++) begin
      step(1, 1, 16'(16'h5000 + 2 * g),     0, 0, "d5_wr");
      step(1, 1, 16'(16'h5000 + 2 * g + 1), 0, 0, "d5_wr");
      step(1, 0, 16'h0, 1, 0, "d5_rd");
    end
    step(1, 1, 16'h5FFF, 1, 0, "d5_wr_rd");
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 1, 0, "d5_drain");
    step(1, 0, 16'h0, 1, 0, "d5_underflow");
    wait_sb();
    check("hand.d5_last", dout5, 16'h5FFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
